wb_regfile: RTL and testbench

- Consumer end of the write-back path: accepts the selected write-back word, destination register and RegWrite strobe, and commits them to a 32-entry register file.
- Supplies two combinational read ports to decode, with same-cycle write-back bypass.
- Holds a pending-write scoreboard: decode marks a destination busy at issue, write-back clears it, and the block raises stall on any read-after-write or write-after-write hazard.

---
 rtl/wb_regfile_if.sv | 29 ++
 rtl/wb_regfile.sv | 71 +++++++
 tb/tb_wb_regfile.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/wb_regfile_if.sv
// Bundles the write-back, read-port and issue/scoreboard signals of the register file.
// The master drives the pipeline side and the slave is the register file itself.
interface wb_regfile_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
);
  logic [WIDTH-1:0] wb_data;
  logic [AW-1:0]    wb_rd;
  logic             wb_en;
  logic [AW-1:0]    rs1;
  logic [AW-1:0]    rs2;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;
  logic             issue_en;
  logic [AW-1:0]    issue_rd;
  logic             stall;
  logic [AW:0]      pending;
  logic             err;

  modport master (
    output wb_data, wb_rd, wb_en, rs1, rs2, issue_en, issue_rd,
    input  rd1, rd2, stall, pending, err
  );

  modport slave (
    input  wb_data, wb_rd, wb_en, rs1, rs2, issue_en, issue_rd,
    output rd1, rd2, stall, pending, err
  );
endinterface

// File: rtl/wb_regfile.sv
// 32-entry register file with write-back bypass and a pending-write scoreboard
// that stalls issue on read-after-write and write-after-write hazards.
module wb_regfile #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input logic         clk,
  input logic         reset,
  wb_regfile_if.slave bus
);
  localparam int N = 2 ** AW;

  logic [WIDTH-1:0] regs [N];
  logic [N-1:0]     busy;
  logic [AW:0]      pendingQ;
  logic             errQ;

  logic wbHit1, wbHit2, wbHitIssue;
  logic hz1, hz2, hzw;
  logic doSet, doClr;
  logic incr, decr;

  assign wbHit1     = bus.wb_en && (bus.wb_rd == bus.rs1);
  assign wbHit2     = bus.wb_en && (bus.wb_rd == bus.rs2);
  assign wbHitIssue = bus.wb_en && (bus.wb_rd == bus.issue_rd);

  assign bus.rd1 = (bus.rs1 == '0) ? '0 : (wbHit1 ? bus.wb_data : regs[bus.rs1]);
  assign bus.rd2 = (bus.rs2 == '0) ? '0 : (wbHit2 ? bus.wb_data : regs[bus.rs2]);

  // A write-back landing this cycle resolves the hazard on that register.
  assign hz1 = (bus.rs1 != '0) && busy[bus.rs1] && !wbHit1;
  assign hz2 = (bus.rs2 != '0) && busy[bus.rs2] && !wbHit2;
  assign hzw = bus.issue_en && (bus.issue_rd != '0) && busy[bus.issue_rd] && !wbHitIssue;

  assign bus.stall = bus.issue_en && (hz1 || hz2 || hzw);

  assign doSet = bus.issue_en && !bus.stall && (bus.issue_rd != '0);
  assign doClr = bus.wb_en && (bus.wb_rd != '0);

  // An accepted issue onto a busy register means that register is being cleared
  // in the same cycle, so the count is unchanged for it.
  assign incr = doSet && !busy[bus.issue_rd];
  assign decr = doClr && busy[bus.wb_rd] && !(doSet && (bus.issue_rd == bus.wb_rd));

  assign bus.pending = pendingQ;
  assign bus.err     = errQ;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        regs[i] <= '0;
      end
      busy     <= '0;
      pendingQ <= '0;
      errQ     <= 1'b0;
    end else begin
      if (doClr) begin
        regs[bus.wb_rd] <= bus.wb_data;
        busy[bus.wb_rd] <= 1'b0;
        if (!busy[bus.wb_rd]) begin
          errQ <= 1'b1;
        end
      end
      // Placed after the clear so a same-register set wins for the new producer.
      if (doSet) begin
        busy[bus.issue_rd] <= 1'b1;
      end
      pendingQ <= pendingQ + {{AW{1'b0}}, incr} - {{AW{1'b0}}, decr};
    end
  end
endmodule

// File: tb/tb_wb_regfile.sv
// Directed-vector bench for wb_regfile: stimulus pushes expected outputs into a
// queue and a negedge monitor pops and compares them.
module tb_wb_regfile;
  localparam int WIDTH = 32;
  localparam int AW    = 5;

  localparam logic [4:0] M_RD1  = 5'b10000;
  localparam logic [4:0] M_RD2  = 5'b01000;
  localparam logic [4:0] M_STL  = 5'b00100;
  localparam logic [4:0] M_PND  = 5'b00010;
  localparam logic [4:0] M_ERR  = 5'b00001;
  localparam logic [4:0] M_CTRL = 5'b00111;

  typedef struct {
    string       name;
    logic [4:0]  mask;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        stall;
    logic [5:0]  pending;
    logic        err;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t expQ[$];

  wb_regfile_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  wb_regfile #(.WIDTH(WIDTH), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(
    input string       name,
    input logic        rst,
    input logic        wbEn,
    input logic [4:0]  wbRd,
    input logic [31:0] wbData,
    input logic [4:0]  r1,
    input logic [4:0]  r2,
    input logic        isEn,
    input logic [4:0]  isRd,
    input logic [4:0]  mask,
    input logic [31:0] eRd1,
    input logic [31:0] eRd2,
    input logic        eStall,
    input logic [5:0]  ePend,
    input logic        eErr
  );
    exp_t e;
    @(posedge clk);
    #1;
    reset        = rst;
    bus.wb_en    = wbEn;
    bus.wb_rd    = wbRd;
    bus.wb_data  = wbData;
    bus.rs1      = r1;
    bus.rs2      = r2;
    bus.issue_en = isEn;
    bus.issue_rd = isRd;
    if (mask != '0) begin
      e.name    = name;
      e.mask    = mask;
      e.rd1     = eRd1;
      e.rd2     = eRd2;
      e.stall   = eStall;
      e.pending = ePend;
      e.err     = eErr;
      expQ.push_back(e);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    if (e.mask[4]) begin
      checks++;
      if (bus.rd1 !== e.rd1) begin
        errors++;
        $display("[TB] FAIL %s rd1 got %h want %h", e.name, bus.rd1, e.rd1);
      end
    end
    if (e.mask[3]) begin
      checks++;
      if (bus.rd2 !== e.rd2) begin
        errors++;
        $display("[TB] FAIL %s rd2 got %h want %h", e.name, bus.rd2, e.rd2);
      end
    end
    if (e.mask[2]) begin
      checks++;
      if (bus.stall !== e.stall) begin
        errors++;
        $display("[TB] FAIL %s stall got %b want %b", e.name, bus.stall, e.stall);
      end
    end
    if (e.mask[1]) begin
      checks++;
      if (bus.pending !== e.pending) begin
        errors++;
        $display("[TB] FAIL %s pending got %0d want %0d", e.name, bus.pending, e.pending);
      end
    end
    if (e.mask[0]) begin
      checks++;
      if (bus.err !== e.err) begin
        errors++;
        $display("[TB] FAIL %s err got %b want %b", e.name, bus.err, e.err);
      end
    end
  endtask

  // Monitor: compares the DUT against the oldest queued expectation mid-cycle.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      checkOutput(expQ.pop_front());
    end
  end

  initial begin
    int p;
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    bus.wb_en    = 1'b0;
    bus.wb_rd    = '0;
    bus.wb_data  = '0;
    bus.rs1      = '0;
    bus.rs2      = '0;
    bus.issue_en = 1'b0;
    bus.issue_rd = '0;
    repeat (2) @(posedge clk);

    applyStimulus("resetRead", 0, 0, 0, 0, 5, 0, 0, 0, 5'b11111, 0, 0, 0, 0, 0);
    applyStimulus("issue3", 0, 0, 0, 0, 0, 0, 1, 3, M_CTRL, 0, 0, 0, 0, 0);
    applyStimulus("bypass3", 0, 1, 3, 32'hDEADBEEF, 3, 0, 0, 0, 5'b11111,
                  32'hDEADBEEF, 0, 0, 1, 0);
    applyStimulus("array3", 0, 0, 0, 0, 3, 0, 0, 0, 5'b10111, 32'hDEADBEEF, 0, 0, 0, 0);

    applyStimulus("issue7", 0, 0, 0, 0, 0, 0, 1, 7, M_CTRL, 0, 0, 0, 0, 0);
    applyStimulus("rawStall", 0, 0, 0, 0, 0, 7, 1, 8, 5'b01111, 0, 0, 1, 1, 0);
    applyStimulus("rawResolve", 0, 1, 7, 32'h77, 0, 7, 1, 8, 5'b01111, 0, 32'h77, 0, 1, 0);

    applyStimulus("issue9", 0, 0, 0, 0, 0, 0, 1, 9, M_CTRL, 0, 0, 0, 1, 0);
    applyStimulus("wawStall", 0, 0, 0, 0, 0, 0, 1, 9, M_CTRL, 0, 0, 1, 2, 0);
    applyStimulus("setClr9", 0, 1, 9, 32'h99, 0, 0, 1, 9, M_CTRL, 0, 0, 0, 2, 0);
    applyStimulus("still9Busy", 0, 0, 0, 0, 9, 0, 1, 9, 5'b10111, 32'h99, 0, 1, 2, 0);

    applyStimulus("r0Write", 0, 1, 0, 32'h1234, 0, 0, 0, 0, 5'b11111, 0, 0, 0, 2, 0);
    applyStimulus("r0After", 0, 0, 0, 0, 0, 0, 0, 0, 5'b10111, 0, 0, 0, 2, 0);
    applyStimulus("errWrite", 0, 1, 12, 32'hABCD1234, 12, 0, 0, 0, 5'b10111,
                  32'hABCD1234, 0, 0, 2, 0);
    applyStimulus("errSticky", 0, 0, 0, 0, 12, 12, 0, 0, 5'b11111,
                  32'hABCD1234, 32'hABCD1234, 0, 2, 1);

    applyStimulus("issue20", 0, 0, 0, 0, 0, 0, 1, 20, M_CTRL, 0, 0, 0, 2, 1);
    applyStimulus("issue21", 0, 0, 0, 0, 0, 0, 1, 21, M_CTRL, 0, 0, 0, 3, 1);
    applyStimulus("resetCycle", 1, 1, 20, 32'h5555, 0, 0, 0, 0, M_CTRL, 0, 0, 0, 4, 1);
    applyStimulus("afterReset", 0, 0, 0, 0, 20, 9, 1, 20, 5'b11111, 0, 0, 0, 0, 0);

    p = 1;
    for (int i = 1; i < 32; i++) begin
      if (i != 20) begin
        applyStimulus("fillBusy", 0, 0, 0, 0, 0, 0, 1, 5'(i), M_STL | M_PND,
                      0, 0, 0, 6'(p), 0);
        p++;
      end
    end
    applyStimulus("allBusy", 0, 0, 0, 0, 0, 0, 0, 0, M_STL | M_PND, 0, 0, 0, 31, 0);
    applyStimulus("issueR0", 0, 0, 0, 0, 0, 0, 1, 0, M_STL | M_PND, 0, 0, 0, 31, 0);
    applyStimulus("issueBusy5", 0, 0, 0, 0, 0, 0, 1, 5, M_STL | M_PND, 0, 0, 1, 31, 0);
    applyStimulus("idle", 0, 0, 0, 0, 0, 0, 0, 0, M_PND | M_ERR, 0, 0, 0, 31, 0);

    @(posedge clk);
    #1;
    bus.issue_en = 1'b0;
    repeat (3) @(posedge clk);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain queue left %0d want 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
